predecode_int: RTL and testbench

Instruction register and interrupt front-end for the 6502C core. Sits directly upstream of the opcode-to-control-signal FSM. Latches each fetched opcode from the data bus on the SYNC cycle, and substitutes a forced BRK (0x00) when a reset, NMI or IRQ is pending. Also delivers a registered instruction class and a one-hot interrupt source vector to the FSM.

---
 rtl/predecode_int_pkg.sv | 19 +
 rtl/predecode_int_sync.sv | 84 ++++++++
 rtl/predecode_int.sv | 110 +++++++++++
 tb/tb_predecode_int.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/predecode_int_pkg.sv
// Shared constants for the predecode / interrupt front-end of the 6502C core:
// instruction class encodings, int_type bit positions and the forced BRK opcode.
package predecode_int_pkg;

  typedef enum logic [1:0] {
    CLASS_NORM   = 2'd0,
    CLASS_RMW    = 2'd1,
    CLASS_BRANCH = 2'd2,
    CLASS_BRK    = 2'd3
  } instr_class_e;

  localparam int RST_i = 0;
  localparam int NMI_i = 1;
  localparam int IRQ_i = 2;
  localparam int BRK_i = 3;

  localparam logic [7:0] BRK_OPCODE = 8'h00;

endpackage

// File: rtl/predecode_int_sync.sv
// int_sync: phi2-qualified sampling of the NMI and IRQ pins plus NMI falling-edge
// detection. Build option INT_SYNC_EN selects a 2-flop synchroniser per pin
// (2-strobe latency); otherwise a single sample flop is used (1-strobe latency).
module int_sync (
  input  logic clk,
  input  logic rst,
  input  logic phi2_en,
  input  logic nmi_n,
  input  logic irq_n,
  output logic nmi_fall,
  output logic irq_s
);

`ifdef INT_SYNC_EN
  logic nmi_meta_q, nmi_meta_d;
  logic irq_meta_q, irq_meta_d;
  logic nmi_s_q, nmi_s_d;
  logic irq_s_q, irq_s_d;

  // Advance both synchroniser chains only on phi2 strobes.
  always_comb begin
    nmi_meta_d = nmi_meta_q;
    irq_meta_d = irq_meta_q;
    nmi_s_d    = nmi_s_q;
    irq_s_d    = irq_s_q;
    if (phi2_en) begin
      nmi_meta_d = nmi_n;
      irq_meta_d = irq_n;
      nmi_s_d    = nmi_meta_q;
      irq_s_d    = irq_meta_q;
    end
  end

  // Synchroniser flops idle high (pins inactive) out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_meta_q <= 1'b1;
      irq_meta_q <= 1'b1;
      nmi_s_q    <= 1'b1;
      irq_s_q    <= 1'b1;
    end else begin
      nmi_meta_q <= nmi_meta_d;
      irq_meta_q <= irq_meta_d;
      nmi_s_q    <= nmi_s_d;
      irq_s_q    <= irq_s_d;
    end
  end

  // The second stage doubles as edge history: a fall is seen when it is still
  // high while the value about to enter it is low.
  assign nmi_fall = phi2_en & nmi_s_q & ~nmi_meta_q;
  assign irq_s    = irq_s_q;
`else
  logic nmi_s_q, nmi_s_d;
  logic irq_s_q, irq_s_d;

  // Sample both pins once per phi2 strobe.
  always_comb begin
    nmi_s_d = nmi_s_q;
    irq_s_d = irq_s_q;
    if (phi2_en) begin
      nmi_s_d = nmi_n;
      irq_s_d = irq_n;
    end
  end

  // Sample flops idle high (pins inactive) out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_s_q <= 1'b1;
      irq_s_q <= 1'b1;
    end else begin
      nmi_s_q <= nmi_s_d;
      irq_s_q <= irq_s_d;
    end
  end

  // The sample flop holds the previous level, so a fall is flagged on the
  // strobe that first samples the pin low.
  assign nmi_fall = phi2_en & nmi_s_q & ~nmi_n;
  assign irq_s    = irq_s_q;
`endif

endmodule

// File: rtl/predecode_int.sv
// predecode_int: instruction register and interrupt front-end. Latches the opcode
// on the SYNC cycle, forcing BRK when reset/NMI/IRQ is pending, and registers the
// instruction class and one-hot interrupt source alongside it.
// Build option: INT_SYNC_EN (2-flop pin synchronisers inside int_sync).
module predecode_int
  import predecode_int_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       phi1_en,
  input  logic       phi2_en,
  input  logic       rdy,
  input  logic       sync,
  input  logic [7:0] data_in,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       i_flag,
  input  logic       int_ack,
  output logic [7:0] opcode_out,
  output logic [3:0] int_type,
  output logic       int_pending,
  output logic [1:0] instr_class
);

  logic         nmi_fall;
  logic         irq_s;
  logic         irq_req;
  logic         load;

  logic         rst_pend_q, rst_pend_d;
  logic         nmi_pend_q, nmi_pend_d;
  logic [7:0]   opcode_q, opcode_d;
  logic [3:0]   int_type_q, int_type_d;
  instr_class_e instr_class_q, instr_class_d;

  // Opcode class from the byte actually being loaded into the register.
  function automatic instr_class_e decode_class(input logic [7:0] op);
    instr_class_e cls;
    cls = CLASS_NORM;
    if (op == BRK_OPCODE)
      cls = CLASS_BRK;
    else if (op[4:0] == 5'b10000)
      cls = CLASS_BRANCH;
    else if ((op[2:0] == 3'b110) && (op[7:5] != 3'd4) && (op[7:5] != 3'd5))
      cls = CLASS_RMW;
    return cls;
  endfunction

  int_sync u_int_sync (
    .clk      (clk),
    .rst      (rst),
    .phi2_en  (phi2_en),
    .nmi_n    (nmi_n),
    .irq_n    (irq_n),
    .nmi_fall (nmi_fall),
    .irq_s    (irq_s)
  );

  assign irq_req     = ~irq_s & ~i_flag;
  assign int_pending = rst_pend_q | nmi_pend_q | irq_req;
  assign load        = phi1_en & sync & rdy;

  // Pending-source tracking and instruction-register next state.
  always_comb begin
    rst_pend_d    = rst_pend_q & ~(int_ack & int_type_q[RST_i]);
    nmi_pend_d    = nmi_fall | (nmi_pend_q & ~(int_ack & int_type_q[NMI_i]));
    opcode_d      = opcode_q;
    int_type_d    = int_type_q;
    instr_class_d = instr_class_q;
    if (load) begin
      int_type_d = 4'b0000;
      if (int_pending) begin
        opcode_d = BRK_OPCODE;
        if (rst_pend_q)
          int_type_d[RST_i] = 1'b1;
        else if (nmi_pend_q)
          int_type_d[NMI_i] = 1'b1;
        else
          int_type_d[IRQ_i] = 1'b1;
      end else begin
        opcode_d = data_in;
        if (data_in == BRK_OPCODE)
          int_type_d[BRK_i] = 1'b1;
      end
      instr_class_d = decode_class(opcode_d);
    end
  end

  // State registers; reset restarts with a pending reset interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_pend_q    <= 1'b1;
      nmi_pend_q    <= 1'b0;
      opcode_q      <= BRK_OPCODE;
      int_type_q    <= 4'b0001;
      instr_class_q <= CLASS_BRK;
    end else begin
      rst_pend_q    <= rst_pend_d;
      nmi_pend_q    <= nmi_pend_d;
      opcode_q      <= opcode_d;
      int_type_q    <= int_type_d;
      instr_class_q <= instr_class_d;
    end
  end

  assign opcode_out  = opcode_q;
  assign int_type    = int_type_q;
  assign instr_class = instr_class_q;

endmodule

// File: tb/tb_predecode_int.sv
// Directed bench for predecode_int: reset state, forced-BRK interrupts, NMI/ack
// collision, IRQ masking, rdy freeze, class decode and mid-instruction reset.
module tb_predecode_int;

`ifdef INT_SYNC_EN
  localparam int NMI_LAT = 2;
`else
  localparam int NMI_LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic       phi1_en;
  logic       phi2_en;
  logic       rdy;
  logic       sync;
  logic [7:0] data_in;
  logic       nmi_n;
  logic       irq_n;
  logic       i_flag;
  logic       int_ack;
  logic [7:0] opcode_out;
  logic [3:0] int_type;
  logic       int_pending;
  logic [1:0] instr_class;

  int check_count = 0;
  int error_count = 0;

  predecode_int dut (
    .clk         (clk),
    .rst         (rst),
    .phi1_en     (phi1_en),
    .phi2_en     (phi2_en),
    .rdy         (rdy),
    .sync        (sync),
    .data_in     (data_in),
    .nmi_n       (nmi_n),
    .irq_n       (irq_n),
    .i_flag      (i_flag),
    .int_ack     (int_ack),
    .opcode_out  (opcode_out),
    .int_type    (int_type),
    .int_pending (int_pending),
    .instr_class (instr_class)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle with the given strobes/ack; returns 1 time unit after the edge.
  task automatic applyStimulus(input logic p1, input logic p2, input logic ack);
    phi1_en = p1;
    phi2_en = p2;
    int_ack = ack;
    @(posedge clk);
    #1;
    phi1_en = 1'b0;
    phi2_en = 1'b0;
    int_ack = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    check_count++;
    assert (observed === expected)
    else begin
      error_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic loadOp(input logic [7:0] op);
    sync    = 1'b1;
    data_in = op;
    applyStimulus(1'b1, 1'b0, 1'b0);
    sync    = 1'b0;
  endtask

  task automatic strobePhi2(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0);
  endtask

  task automatic checkLoad(input string tag, input logic [7:0] op, input logic [3:0] it, input logic [1:0] cls);
    checkOutput({tag, "_op"}, opcode_out, op);
    checkOutput({tag, "_type"}, {4'b0, int_type}, {4'b0, it});
    checkOutput({tag, "_class"}, {6'b0, instr_class}, {6'b0, cls});
  endtask

  logic [7:0] vec_op  [6];
  logic [1:0] vec_cls [6];

  initial begin
    vec_op  = '{8'h1E, 8'h96, 8'hBE, 8'h10, 8'hC6, 8'hFE};
    vec_cls = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd1, 2'd1};

    rst = 1'b1; phi1_en = 1'b0; phi2_en = 1'b0; rdy = 1'b1; sync = 1'b0;
    data_in = 8'h00; nmi_n = 1'b1; irq_n = 1'b1; i_flag = 1'b1; int_ack = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checkLoad("reset", 8'h00, 4'b0001, 2'd3);
    checkOutput("reset_pending", {7'b0, int_pending}, 8'd1);

    // Reset interrupt is serviced first, then the real opcode loads.
    loadOp(8'hA9);
    checkLoad("rst_brk", 8'h00, 4'b0001, 2'd3);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("rst_acked", {7'b0, int_pending}, 8'd0);
    loadOp(8'hA9);
    checkLoad("lda", 8'hA9, 4'b0000, 2'd0);

    // NMI falling edge forces BRK, ack clears it.
    nmi_n = 1'b0;
    strobePhi2(2);
    checkOutput("nmi_pending", {7'b0, int_pending}, 8'd1);
    loadOp(8'h0E);
    checkLoad("nmi_brk", 8'h00, 4'b0010, 2'd3);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("nmi_acked", {7'b0, int_pending}, 8'd0);
    loadOp(8'h0E);
    checkLoad("asl_abs", 8'h0E, 4'b0000, 2'd1);

    // Masked IRQ is ignored; unmasking forces BRK with irq source.
    i_flag = 1'b1;
    irq_n  = 1'b0;
    strobePhi2(2);
    checkOutput("irq_masked", {7'b0, int_pending}, 8'd0);
    loadOp(8'hD0);
    checkLoad("bne", 8'hD0, 4'b0000, 2'd2);
    i_flag = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("irq_unmasked", {7'b0, int_pending}, 8'd1);
    loadOp(8'hD0);
    checkLoad("irq_brk", 8'h00, 4'b0100, 2'd3);
    irq_n = 1'b1;
    strobePhi2(2);
    checkOutput("irq_released", {7'b0, int_pending}, 8'd0);

    // New NMI edge coinciding with the ack of the previous NMI keeps it pending.
    nmi_n = 1'b1;
    strobePhi2(2);
    nmi_n = 1'b0;
    strobePhi2(2);
    loadOp(8'hEA);
    checkLoad("nmi2_brk", 8'h00, 4'b0010, 2'd3);
    nmi_n = 1'b1;
    strobePhi2(2);
    nmi_n = 1'b0;
    strobePhi2(NMI_LAT - 1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("nmi_set_wins", {7'b0, int_pending}, 8'd1);
    loadOp(8'hEA);
    checkLoad("nmi3_brk", 8'h00, 4'b0010, 2'd3);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("nmi3_acked", {7'b0, int_pending}, 8'd0);

    // rdy low freezes the instruction register.
    rdy = 1'b0;
    loadOp(8'h4C);
    checkLoad("rdy_hold", 8'h00, 4'b0010, 2'd3);
    rdy = 1'b1;
    loadOp(8'h4C);
    checkLoad("jmp", 8'h4C, 4'b0000, 2'd0);

    // Genuine BRK opcode from the bus.
    loadOp(8'h00);
    checkLoad("brk_op", 8'h00, 4'b1000, 2'd3);

    // Class decode boundaries: rmw modes, STX/LDX exclusions, branch.
    for (int i = 0; i < 6; i++) begin
      loadOp(vec_op[i]);
      checkLoad($sformatf("class_%02h", vec_op[i]), vec_op[i], 4'b0000, vec_cls[i]);
    end

    // Reset mid-instruction with an NMI pending and rdy low.
    nmi_n = 1'b1;
    strobePhi2(2);
    nmi_n = 1'b0;
    strobePhi2(2);
    checkOutput("pre_rst_nmi", {7'b0, int_pending}, 8'd1);
    rdy = 1'b0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    rdy = 1'b1;
    checkLoad("mid_rst", 8'h00, 4'b0001, 2'd3);
    checkOutput("mid_rst_pending", {7'b0, int_pending}, 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("nmi_cleared_by_rst", {7'b0, int_pending}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
